// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the RV32I multicycle control FSM.
// Covers state names, opcodes, ALU controls, mux selects and the immediate-type decoder.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXEC_R,
        EXEC_I,
        ALUWB,
        BRANCH,
        JAL,
        TRAP
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] imm;
        case (op)
            OP_STORE:  imm = IMM_S;
            OP_BRANCH: imm = IMM_B;
            OP_JAL:    imm = IMM_J;
            default:   imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/mc_alu_op_dec.sv
// ALU control decoder: maps ALUOp plus instruction fields to the 3-bit ALU control.
// Flags funct3 values the datapath ALU cannot execute so the FSM can trap on them.
module mc_alu_op_dec
    import mc_ctrl_pkg::*;
(
    input  alu_op_t    i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_op5,
    output logic [2:0] o_alu_control,
    output logic       o_illegal
);

    always_comb begin
        o_alu_control = ALU_ADD;
        o_illegal     = 1'b0;
        case (i_alu_op)
            ALUOP_ADD: o_alu_control = ALU_ADD;
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // funct7b5 only selects sub for R-type; addi ignores it
                    3'b000:  o_alu_control = (i_op5 && i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_illegal = 1'b1;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_fsm_ctrl.sv
// Multicycle control FSM for an RV32I subset sharing one ALU and one unified memory.
// Stalls on mem_ready, traps (sticky until reset) on illegal opcodes or memory timeout.
module mc_fsm_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [6:0] i_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_pc_write,
    output logic       o_adr_src,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic [1:0] o_result_src,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_imm_src,
    output logic [2:0] o_alu_control,
    output logic       o_reg_write,
    output logic       o_instr_done,
    output logic       o_trap,
    output logic       o_trap_cause
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_next;
    logic             r_trap_cause;
    logic             w_trap_cause_next;
    logic             w_waiting;
    logic             w_timeout;
    alu_op_t          w_alu_op;
    logic             w_alu_illegal;

    mc_alu_op_dec u_alu_op_dec (
        .i_alu_op      (w_alu_op),
        .i_funct3      (i_funct3),
        .i_funct7b5    (i_funct7b5),
        .i_op5         (i_op[5]),
        .o_alu_control (o_alu_control),
        .o_illegal     (w_alu_illegal)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= FETCH;
            r_wait_cnt   <= '0;
            r_trap_cause <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_wait_cnt   <= w_wait_cnt_next;
            r_trap_cause <= w_trap_cause_next;
        end
    end

    assign w_waiting = (r_state == FETCH) || (r_state == MEMREAD) || (r_state == MEMWRITE);
    // mem_ready takes priority: the timeout only fires while the access is still pending
    assign w_timeout = (TIMEOUT_CYCLES != 0) && w_waiting && !i_mem_ready &&
                       (r_wait_cnt == CNT_LAST);

    always_comb begin
        w_next_state      = r_state;
        w_trap_cause_next = r_trap_cause;
        case (r_state)
            FETCH, MEMREAD, MEMWRITE: begin
                if (i_mem_ready) begin
                    case (r_state)
                        FETCH:   w_next_state = DECODE;
                        MEMREAD: w_next_state = MEMWB;
                        default: w_next_state = FETCH;
                    endcase
                end else if (w_timeout) begin
                    w_next_state      = TRAP;
                    w_trap_cause_next = 1'b1;
                end
            end
            DECODE: begin
                case (i_op)
                    OP_LOAD, OP_STORE: w_next_state = MEMADR;
                    OP_RTYPE:          w_next_state = EXEC_R;
                    OP_ITYPE:          w_next_state = EXEC_I;
                    OP_BRANCH:         w_next_state = BRANCH;
                    OP_JAL:            w_next_state = JAL;
                    default: begin
                        w_next_state      = TRAP;
                        w_trap_cause_next = 1'b0;
                    end
                endcase
            end
            MEMADR:  w_next_state = i_op[5] ? MEMWRITE : MEMREAD;
            MEMWB:   w_next_state = FETCH;
            EXEC_R, EXEC_I: begin
                if (w_alu_illegal) begin
                    w_next_state      = TRAP;
                    w_trap_cause_next = 1'b0;
                end else begin
                    w_next_state = ALUWB;
                end
            end
            ALUWB:   w_next_state = FETCH;
            BRANCH:  w_next_state = FETCH;
            JAL:     w_next_state = ALUWB;
            TRAP:    w_next_state = TRAP;
            default: w_next_state = FETCH;
        endcase
    end

    always_comb begin
        if (w_next_state != r_state) begin
            w_wait_cnt_next = '0;
        end else if (w_waiting && !i_mem_ready && (r_wait_cnt != CNT_MAX)) begin
            w_wait_cnt_next = r_wait_cnt + 1'b1;
        end else begin
            w_wait_cnt_next = r_wait_cnt;
        end
    end

    always_comb begin
        o_pc_write   = 1'b0;
        o_adr_src    = 1'b0;
        o_mem_write  = 1'b0;
        o_ir_write   = 1'b0;
        o_result_src = RES_ALUOUT;
        o_alu_src_a  = SRCA_PC;
        o_alu_src_b  = SRCB_RS2;
        o_reg_write  = 1'b0;
        o_instr_done = 1'b0;
        w_alu_op     = ALUOP_ADD;
        case (r_state)
            FETCH: begin
                o_alu_src_b  = SRCB_FOUR;
                o_result_src = RES_ALURESULT;
                o_ir_write   = i_mem_ready;
                o_pc_write   = i_mem_ready;
            end
            DECODE: begin
                o_alu_src_a = SRCA_OLDPC;
                o_alu_src_b = SRCB_IMM;
            end
            MEMADR: begin
                o_alu_src_a = SRCA_RS1;
                o_alu_src_b = SRCB_IMM;
            end
            MEMREAD: o_adr_src = 1'b1;
            MEMWB: begin
                o_result_src = RES_DATA;
                o_reg_write  = 1'b1;
                o_instr_done = 1'b1;
            end
            MEMWRITE: begin
                o_adr_src    = 1'b1;
                o_mem_write  = 1'b1;
                o_instr_done = i_mem_ready;
            end
            EXEC_R: begin
                o_alu_src_a = SRCA_RS1;
                w_alu_op    = ALUOP_FUNCT;
            end
            EXEC_I: begin
                o_alu_src_a = SRCA_RS1;
                o_alu_src_b = SRCB_IMM;
                w_alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                o_reg_write  = 1'b1;
                o_instr_done = 1'b1;
            end
            BRANCH: begin
                o_alu_src_a  = SRCA_RS1;
                w_alu_op     = ALUOP_SUB;
                // funct3[0] inverts the condition: beq takes on zero, bne on non-zero
                o_pc_write   = i_zero ^ i_funct3[0];
                o_instr_done = 1'b1;
            end
            JAL: begin
                o_alu_src_a = SRCA_OLDPC;
                o_alu_src_b = SRCB_FOUR;
                o_pc_write  = 1'b1;
            end
            default: begin
            end
        endcase
        if (i_reset) begin
            o_pc_write   = 1'b0;
            o_ir_write   = 1'b0;
            o_reg_write  = 1'b0;
            o_mem_write  = 1'b0;
            o_instr_done = 1'b0;
        end
    end

    assign o_imm_src    = imm_src_of(i_op);
    assign o_trap       = (r_state == TRAP);
    assign o_trap_cause = r_trap_cause;

endmodule
